// File: rtl/alu_sequencer.sv
// Control-side sequencer for the 8-bit 6502 ALU: owns the accumulator and N/Z/C/V,
// fetches memory operands and does read-modify-write shifts. Optional macro: ALU_SEQ_TIMEOUT_EN.
module alu_sequencer #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [3:0]        op_code,
    input  logic              op_mem,
    input  logic [7:0]        op_imm,
    input  logic [ADDR_W-1:0] op_addr,
    output logic              done,
    output logic              op_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack,
    output logic [7:0]        alu_a,
    output logic [7:0]        alu_mem,
    output logic              alu_subtract,
    output logic              alu_target_bus,
    output logic              alu_carry_in,
    output logic              alu_sum_sel,
    output logic              alu_and_sel,
    output logic              alu_xor_sel,
    output logic              alu_or_sel,
    output logic              alu_asl_sel,
    output logic              alu_lsr_sel,
    output logic              alu_rol_sel,
    output logic              alu_ror_sel,
    input  logic [7:0]        alu_out,
    input  logic              alu_overflow,
    input  logic              alu_carry,
    input  logic              alu_zero,
    input  logic              alu_negative,
    output logic [7:0]        acc,
    output logic [3:0]        flags
);

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_SBC = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_ORA = 4'd3;
    localparam logic [3:0] OP_EOR = 4'd4;
    localparam logic [3:0] OP_ASL = 4'd5;
    localparam logic [3:0] OP_LSR = 4'd6;
    localparam logic [3:0] OP_ROL = 4'd7;
    localparam logic [3:0] OP_ROR = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WRITE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [3:0]          r_op;
    logic                r_mem;
    logic [ADDR_W-1:0]   r_addr;
    logic [7:0]          r_operand;
    logic [7:0]          r_result;
    logic [7:0]          r_acc;
    logic [3:0]          r_flags;
    logic                r_done;
    logic                r_err;
    logic [CNT_W-1:0]    r_cnt;
    logic                w_accept;
    logic                w_illegal;
    logic                w_shift;
    logic                w_mem_wait;
    logic                w_timeout;

    assign w_accept   = op_valid && (r_state == S_IDLE);
    assign w_illegal  = (op_code > OP_CMP);
    assign w_shift    = (r_op >= OP_ASL) && (r_op <= OP_ROR);
    assign w_mem_wait = (r_state == S_READ) || (r_state == S_WRITE);
    // The counter always runs; it only has an effect when the timeout build is selected.
    assign w_timeout  = TIMEOUT_EN && w_mem_wait && !mem_ack && (r_cnt == CNT_LAST);

    assign op_ready  = (r_state == S_IDLE);
    assign mem_addr  = r_addr;
    assign mem_wdata = r_result;
    assign alu_a     = r_acc;
    assign alu_mem   = r_operand;
    assign acc       = r_acc;
    assign flags     = r_flags;
    assign done      = r_done;
    assign op_err    = r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_op      <= 4'd0;
            r_mem     <= 1'b0;
            r_addr    <= '0;
            r_operand <= 8'h00;
            r_result  <= 8'h00;
            r_acc     <= 8'h00;
            r_flags   <= 4'b0000;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_cnt   <= (w_mem_wait && !mem_ack) ? r_cnt + CNT_W'(1) : '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op   <= op_code;
                        r_mem  <= op_mem;
                        r_addr <= op_addr;
                        if (w_illegal) begin
                            r_done <= 1'b1;
                            r_err  <= 1'b1;
                        end else if (!op_mem) begin
                            r_operand <= op_imm;
                        end
                    end
                end
                S_READ: begin
                    if (mem_ack) begin
                        r_operand <= mem_rdata;
                    end else if (w_timeout) begin
                        r_done <= 1'b1;
                        r_err  <= 1'b1;
                    end
                end
                S_EXEC: begin
                    // flags layout {N,V,Z,C}
                    case (r_op)
                        OP_ADC, OP_SBC: begin
                            r_acc   <= alu_out;
                            r_flags <= {alu_negative, alu_overflow, alu_zero, alu_carry};
                        end
                        OP_AND, OP_ORA, OP_EOR: begin
                            r_acc      <= alu_out;
                            r_flags[3] <= alu_negative;
                            r_flags[1] <= alu_zero;
                        end
                        OP_CMP: begin
                            r_flags[3] <= alu_negative;
                            r_flags[1] <= alu_zero;
                            r_flags[0] <= alu_carry;
                        end
                        default: begin
                            if (r_mem) begin
                                r_result <= alu_out;
                            end else begin
                                r_acc <= alu_out;
                            end
                            r_flags[3] <= alu_negative;
                            r_flags[1] <= alu_zero;
                            r_flags[0] <= alu_carry;
                        end
                    endcase
                    if (!(w_shift && r_mem)) begin
                        r_done <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (mem_ack) begin
                        r_done <= 1'b1;
                    end else if (w_timeout) begin
                        r_done <= 1'b1;
                        r_err  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next         = r_state;
        mem_req        = 1'b0;
        mem_we         = 1'b0;
        alu_subtract   = 1'b0;
        alu_target_bus = 1'b0;
        alu_carry_in   = 1'b0;
        alu_sum_sel    = 1'b0;
        alu_and_sel    = 1'b0;
        alu_xor_sel    = 1'b0;
        alu_or_sel     = 1'b0;
        alu_asl_sel    = 1'b0;
        alu_lsr_sel    = 1'b0;
        alu_rol_sel    = 1'b0;
        alu_ror_sel    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_illegal) begin
                    w_next = op_mem ? S_READ : S_EXEC;
                end
            end
            S_READ: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    w_next = S_EXEC;
                end else if (w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            S_EXEC: begin
                case (r_op)
                    OP_ADC: begin
                        alu_sum_sel  = 1'b1;
                        alu_carry_in = r_flags[0];
                    end
                    OP_SBC: begin
                        alu_sum_sel  = 1'b1;
                        alu_subtract = 1'b1;
                        alu_carry_in = r_flags[0];
                    end
                    OP_CMP: begin
                        alu_sum_sel  = 1'b1;
                        alu_subtract = 1'b1;
                        alu_carry_in = 1'b1;
                    end
                    OP_AND: alu_and_sel = 1'b1;
                    OP_ORA: alu_or_sel  = 1'b1;
                    OP_EOR: alu_xor_sel = 1'b1;
                    OP_ASL: alu_asl_sel = 1'b1;
                    OP_LSR: alu_lsr_sel = 1'b1;
                    OP_ROL: begin
                        alu_rol_sel  = 1'b1;
                        alu_carry_in = r_flags[0];
                    end
                    OP_ROR: begin
                        alu_ror_sel  = 1'b1;
                        alu_carry_in = r_flags[0];
                    end
                    default: ;
                endcase
                alu_target_bus = w_shift && r_mem;
                w_next = (w_shift && r_mem) ? S_WRITE : S_IDLE;
            end
            S_WRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack || w_timeout) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a behavioural 6502 ALU and a latency-programmable memory.
`timescale 1ns/1ps
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic        op_mem;
    logic [7:0]  op_imm;
    logic [15:0] op_addr;
    logic        done;
    logic        op_err;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic [7:0]  alu_a;
    logic [7:0]  alu_mem;
    logic        alu_subtract;
    logic        alu_target_bus;
    logic        alu_carry_in;
    logic        alu_sum_sel;
    logic        alu_and_sel;
    logic        alu_xor_sel;
    logic        alu_or_sel;
    logic        alu_asl_sel;
    logic        alu_lsr_sel;
    logic        alu_rol_sel;
    logic        alu_ror_sel;
    logic [7:0]  alu_out;
    logic        alu_overflow;
    logic        alu_carry;
    logic        alu_zero;
    logic        alu_negative;
    logic [7:0]  acc;
    logic [3:0]  flags;

    int          n_checks = 0;
    int          n_fail   = 0;

    // memory responder controls and observations
    logic [7:0]  mem_byte  = 8'h00;
    int          ack_lat   = 1;
    bit          ack_en    = 1'b1;
    bit          wr_ack_en = 1'b1;
    int          req_cycles = 0;
    int          wr_cnt    = 0;
    logic [15:0] wr_addr   = 16'h0000;
    logic [7:0]  wr_data   = 8'h00;
    logic [15:0] rd_addr   = 16'h0000;
    int          req_seen  = 0;
    bit          saw_asl_bus = 1'b0;

    alu_sequencer #(.ADDR_W(16), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_mem(op_mem),
        .op_imm(op_imm), .op_addr(op_addr), .done(done), .op_err(op_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_a(alu_a), .alu_mem(alu_mem), .alu_subtract(alu_subtract),
        .alu_target_bus(alu_target_bus), .alu_carry_in(alu_carry_in),
        .alu_sum_sel(alu_sum_sel), .alu_and_sel(alu_and_sel), .alu_xor_sel(alu_xor_sel),
        .alu_or_sel(alu_or_sel), .alu_asl_sel(alu_asl_sel), .alu_lsr_sel(alu_lsr_sel),
        .alu_rol_sel(alu_rol_sel), .alu_ror_sel(alu_ror_sel), .alu_out(alu_out),
        .alu_overflow(alu_overflow), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .alu_negative(alu_negative), .acc(acc), .flags(flags)
    );

    always #5 clk = ~clk;

    // Behavioural 6502 ALU: subtract inverts the memory operand, shifts act on alu_mem when target_bus is set.
    logic [7:0] m_src;
    logic [7:0] m_b;
    logic [8:0] m_sum;
    always_comb begin
        alu_out      = 8'h00;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        m_src        = alu_target_bus ? alu_mem : alu_a;
        m_b          = alu_subtract ? ~alu_mem : alu_mem;
        m_sum        = {1'b0, alu_a} + {1'b0, m_b} + {8'h00, alu_carry_in};
        if (alu_sum_sel) begin
            alu_out      = m_sum[7:0];
            alu_carry    = m_sum[8];
            alu_overflow = (alu_a[7] == m_b[7]) && (m_sum[7] != alu_a[7]);
        end else if (alu_and_sel) begin
            alu_out = alu_a & alu_mem;
        end else if (alu_or_sel) begin
            alu_out = alu_a | alu_mem;
        end else if (alu_xor_sel) begin
            alu_out = alu_a ^ alu_mem;
        end else if (alu_asl_sel) begin
            alu_out   = {m_src[6:0], 1'b0};
            alu_carry = m_src[7];
        end else if (alu_lsr_sel) begin
            alu_out   = {1'b0, m_src[7:1]};
            alu_carry = m_src[0];
        end else if (alu_rol_sel) begin
            alu_out   = {m_src[6:0], alu_carry_in};
            alu_carry = m_src[7];
        end else if (alu_ror_sel) begin
            alu_out   = {alu_carry_in, m_src[7:1]};
            alu_carry = m_src[0];
        end
        alu_zero     = (alu_out == 8'h00);
        alu_negative = alu_out[7];
    end

    // Memory: acks in the ack_lat-th cycle of a request.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (mem_req && ack_en && (!mem_we || wr_ack_en)) begin
                req_cycles++;
                if (req_cycles >= ack_lat) begin
                    mem_ack    = 1'b1;
                    req_cycles = 0;
                    if (mem_we) begin
                        wr_cnt++;
                        wr_addr = mem_addr;
                        wr_data = mem_wdata;
                    end else begin
                        rd_addr   = mem_addr;
                        mem_rdata = mem_byte;
                    end
                end
            end else begin
                req_cycles = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (mem_req) req_seen++;
            if (alu_asl_sel && alu_target_bus) saw_asl_bus = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Caller sits at a negedge with op_ready high; returns at the first negedge after the accept edge.
    task automatic issue(input logic [3:0] code, input logic m, input logic [7:0] imm, input logic [15:0] addr);
        op_valid = 1'b1;
        op_code  = code;
        op_mem   = m;
        op_imm   = imm;
        op_addr  = addr;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(negedge clk);
    endtask

    // Latency counts negedges after the accept edge; 0 means done never arrived.
    task automatic wait_done(input int budget, output int lat);
        lat = 0;
        for (int k = 1; k <= budget; k++) begin
            if (done) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    int lat;
    int wr_before;

    initial begin
        rst      = 1'b1;
        op_valid = 1'b0;
        op_code  = 4'd0;
        op_mem   = 1'b0;
        op_imm   = 8'h00;
        op_addr  = 16'h0000;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(op_ready), 32'h1);
        check("rst_acc", 32'(acc), 32'h00);
        check("rst_flags", 32'(flags), 32'h0);
        check("rst_done", 32'({done, op_err}), 32'h0);
        check("rst_mem", 32'({mem_req, mem_we, mem_addr, mem_wdata}), 32'h0);
        check("rst_alu_ctl", 32'({alu_sum_sel, alu_subtract, alu_carry_in, alu_target_bus}), 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // ORA imm 0x50 -> acc 0x50
        issue(4'd3, 1'b0, 8'h50, 16'h0);
        check("ora_sel", 32'(alu_or_sel), 32'h1);
        check("ora_exec_done", 32'(done), 32'h0);
        @(negedge clk);
        check("ora_done", 32'(done), 32'h1);
        check("ora_acc", 32'(acc), 32'h50);
        check("ora_flags", 32'(flags), 32'h0);
        @(negedge clk);

        // ADC 0x50 + 0x50, C=0 -> 0xA0, N=1 V=1
        issue(4'd0, 1'b0, 8'h50, 16'h0);
        check("adc_sel", 32'({alu_sum_sel, alu_subtract, alu_carry_in}), 32'h4);
        check("adc_exec_done", 32'(done), 32'h0);
        @(negedge clk);
        check("adc_done", 32'({done, op_ready, op_err}), 32'h6);
        check("adc_acc", 32'(acc), 32'hA0);
        check("adc_flags", 32'(flags), 32'hC);
        @(negedge clk);
        check("adc_done_pulse", 32'(done), 32'h0);

        // EOR 0xB0 -> acc 0x10, V kept
        issue(4'd4, 1'b0, 8'hB0, 16'h0);
        @(negedge clk);
        check("eor_acc", 32'(acc), 32'h10);
        check("eor_flags", 32'(flags), 32'h4);

        // CMP 0x10 with acc 0x10 -> Z=1 C=1
        issue(4'd9, 1'b0, 8'h10, 16'h0);
        check("cmp_ctl", 32'({alu_sum_sel, alu_subtract, alu_carry_in}), 32'h7);
        @(negedge clk);
        check("cmp_flags", 32'(flags), 32'h7);
        check("cmp_acc", 32'(acc), 32'h10);

        // ASL memory 0x0200 = 0x81, ack latency 3
        mem_byte    = 8'h81;
        ack_lat     = 3;
        req_seen    = 0;
        saw_asl_bus = 1'b0;
        issue(4'd5, 1'b1, 8'h00, 16'h0200);
        check("asl_read_req", 32'({mem_req, mem_we, op_ready}), 32'h4);
        check("asl_read_addr", 32'(mem_addr), 32'h0200);
        wait_done(30, lat);
        check("asl_latency", 32'(lat), 32'd8);
        check("asl_rd_addr", 32'(rd_addr), 32'h0200);
        check("asl_wr_cnt", 32'(wr_cnt), 32'd1);
        check("asl_wr", 32'({wr_addr, wr_data}), 32'h020002);
        check("asl_flags", 32'(flags), 32'h5);
        check("asl_acc", 32'(acc), 32'h10);
        check("asl_req_cycles", 32'(req_seen), 32'd6);
        check("asl_target_bus", 32'(saw_asl_bus), 32'h1);
        check("asl_done_req", 32'(mem_req), 32'h0);

        // Illegal opcode 12
        req_seen = 0;
        issue(4'd12, 1'b0, 8'h00, 16'h0);
        check("ill_done", 32'({done, op_err, op_ready}), 32'h7);
        check("ill_flags", 32'(flags), 32'h5);
        @(negedge clk);
        check("ill_pulse", 32'({done, op_err}), 32'h0);
        check("ill_no_req", 32'(req_seen), 32'd0);

        // ROL acc with C=1, then LSR accepted in the done cycle
        issue(4'd7, 1'b0, 8'h00, 16'h0);
        check("rol_ctl", 32'({alu_rol_sel, alu_carry_in, alu_target_bus}), 32'h6);
        @(negedge clk);
        check("rol_acc", 32'(acc), 32'h21);
        check("rol_flags", 32'({done, flags}), 32'h14);
        issue(4'd6, 1'b0, 8'h00, 16'h0);
        check("lsr_ctl", 32'({alu_lsr_sel, alu_carry_in}), 32'h2);
        @(negedge clk);
        check("lsr_acc", 32'(acc), 32'h10);
        check("lsr_flags", 32'(flags), 32'h5);

        // EOR memory, zero-wait ack
        mem_byte = 8'hFF;
        ack_lat  = 1;
        issue(4'd4, 1'b1, 8'h00, 16'h0011);
        wait_done(10, lat);
        check("eor_m_latency", 32'(lat), 32'd3);
        check("eor_m_acc", 32'(acc), 32'hEF);
        check("eor_m_flags", 32'(flags), 32'hD);
        check("eor_m_rd_addr", 32'(rd_addr), 32'h0011);
        @(negedge clk);

        // Reset during WRITE of a ROL memory op
        mem_byte  = 8'h40;
        wr_ack_en = 1'b0;
        wr_before = wr_cnt;
        issue(4'd7, 1'b1, 8'h00, 16'h0300);
        for (int k = 0; k < 10; k++) begin
            if (mem_we) break;
            @(negedge clk);
        end
        check("rmw_in_write", 32'({mem_req, mem_we}), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_req", 32'(mem_req), 32'h0);
        check("rst_async_state", 32'({op_ready, done}), 32'h2);
        check("rst_async_acc", 32'(acc), 32'h00);
        @(negedge clk);
        rst       = 1'b0;
        wr_ack_en = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst", 32'({op_ready, done, mem_req}), 32'h4);
        check("post_rst_nowrite", 32'(wr_cnt), 32'(wr_before));

`ifdef ALU_SEQ_TIMEOUT_EN
        // AND memory with no ack -> timeout after 16 request cycles
        issue(4'd3, 1'b0, 8'h33, 16'h0);
        @(negedge clk);
        ack_en   = 1'b0;
        req_seen = 0;
        issue(4'd2, 1'b1, 8'h00, 16'h0400);
        wait_done(40, lat);
        check("to_latency", 32'(lat), 32'd17);
        check("to_req_cycles", 32'(req_seen), 32'd16);
        check("to_err", 32'({done, op_err, mem_req}), 32'h6);
        check("to_acc", 32'(acc), 32'h33);
        ack_en = 1'b1;
        @(negedge clk);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
